uart_transmitter: RTL and testbench

Serial 8N1 UART transmitter with an integrated baud-rate tick generator, running entirely in one system clock domain. It accepts a byte on a valid-level interface and shifts it out LSB-first with one start bit and one stop bit. It sits at the edge of the design and drives the off-chip TX line. It reports activity on `tx_busy` so an upstream sequencer can present the next byte.

---
 rtl/uart_transmitter_if.sv | 19 +
 rtl/uart_transmitter.sv | 124 ++++++++++++
 tb/tb_uart_transmitter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Byte-request handshake between an upstream sequencer and the UART transmitter.
// The serial line itself stays a plain port on the transmitter.
interface uart_transmitter_if;
  logic [7:0] data;
  logic       data_valid;
  logic       tx_busy;

  modport master (
    output data,
    output data_valid,
    input  tx_busy
  );

  modport slave (
    input  data,
    input  data_valid,
    output tx_busy
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: free-running baud tick used as a clock enable for a
// four-state frame sequencer; tx and tx_busy come straight from flops.
module uart_transmitter #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_transmitter_if.slave   bus,
  output logic                tx
);

  localparam int DIV   = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic             baud_tick;

  logic [1:0] state_q,     state_d;
  logic [7:0] shift_reg_q, shift_reg_d;
  logic [2:0] bit_idx_q,   bit_idx_d;
  logic       tx_q,        tx_d;
  logic       tx_busy_q,   tx_busy_d;
  logic [2:0] next_idx_s;

  // Baud counter next value and the one-cycle tick at the top of the count
  always_comb begin
    baud_tick = (baud_cnt_q == CNT_MAX);
    if (baud_tick) begin
      baud_cnt_d = {CNT_W{1'b0}};
    end else begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end
  end

  // Frame sequencer next-state; everything holds between ticks
  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    next_idx_s  = bit_idx_q + 3'd1;

    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.data_valid) begin
            shift_reg_d = bus.data;
            tx_d        = 1'b0;
            tx_busy_d   = 1'b1;
            state_d     = ST_START;
          end else begin
            tx_d      = 1'b1;
            tx_busy_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        ST_START: begin
          tx_d      = shift_reg_q[0];
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_idx_q != 3'd7) begin
            tx_d      = shift_reg_q[next_idx_s];
            bit_idx_d = next_idx_s;
            state_d   = ST_DATA;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          // busy drops here, so a held request waits one full idle bit
          tx_d      = 1'b1;
          tx_busy_d = 1'b0;
          state_d   = ST_IDLE;
        end
        default: begin
          tx_d      = 1'b1;
          tx_busy_d = 1'b0;
          bit_idx_d = 3'd0;
          state_d   = ST_IDLE;
        end
      endcase
    end else begin
      state_d     = state_q;
      shift_reg_d = shift_reg_q;
      bit_idx_d   = bit_idx_q;
      tx_d        = tx_q;
      tx_busy_d   = tx_busy_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_q  <= {CNT_W{1'b0}};
      state_q     <= ST_IDLE;
      shift_reg_q <= 8'h00;
      bit_idx_q   <= 3'd0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else begin
      baud_cnt_q  <= baud_cnt_d;
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  assign tx          = tx_q;
  assign bus.tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at DIV=16: frames are decoded by
// mid-bit sampling on the falling clock edge and compared with hand values.
module tb_uart_transmitter;

  logic clk;
  logic rst_n;
  logic tx_s;
  int   n_checks;
  int   n_errors;

  uart_transmitter_if u_if ();

  uart_transmitter #(
    .CLK_FREQ  (16),
    .BAUD_RATE (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if),
    .tx    (tx_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for a start bit, then samples the 10 line bits mid-bit and counts
  // busy cycles; request inputs are updated at frame start and at index chg_i.
  task automatic rx_frame(input logic [7:0] d0, input logic v0, input int chg_i,
                          input logic [7:0] d1, input logic v1,
                          output logic [7:0] byte_o, output logic start_o,
                          output logic stop_o, output int wait_o, output int busy_o);
    logic [9:0] bits;
    bits   = 10'h000;
    wait_o = 0;
    busy_o = 0;
    while (tx_s === 1'b1 && wait_o < 64) begin
      @(negedge clk);
      wait_o++;
    end
    check_eq("start_seen", 32'(tx_s), 32'd0);
    u_if.data       = d0;
    u_if.data_valid = v0;
    for (int i = 0; i < 160; i++) begin
      if (i == chg_i) begin
        u_if.data       = d1;
        u_if.data_valid = v1;
      end
      if (i % 16 == 8) bits[i/16] = tx_s;
      if (u_if.tx_busy === 1'b1) busy_o++;
      @(negedge clk);
    end
    start_o = bits[0];
    byte_o  = bits[8:1];
    stop_o  = bits[9];
  endtask

  logic [7:0] rx_byte;
  logic       rx_start;
  logic       rx_stop;
  int         rx_wait;
  int         rx_busy;
  logic [7:0] exp_str [5];
  logic [7:0] nxt_str [5];

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    u_if.data       = 8'h00;
    u_if.data_valid = 1'b1;

    // 1: reset values, first tick after release, async reset mid-frame
    #23;
    check_eq("rst_tx", 32'(tx_s), 32'd1);
    check_eq("rst_busy", 32'(u_if.tx_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_wait = 0;
    while (tx_s === 1'b1 && rx_wait < 64) begin
      @(negedge clk);
      rx_wait++;
    end
    check_eq("first_tick_clks", 32'(rx_wait), 32'd16);
    check_eq("first_busy", 32'(u_if.tx_busy), 32'd1);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", 32'(tx_s), 32'd1);
    check_eq("async_rst_busy", 32'(u_if.tx_busy), 32'd0);
    u_if.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("idle_tx", 32'(tx_s), 32'd1);

    // 2: single byte 'T'
    u_if.data       = 8'h54;
    u_if.data_valid = 1'b1;
    rx_frame(8'h54, 1'b0, -1, 8'h00, 1'b0, rx_byte, rx_start, rx_stop, rx_wait, rx_busy);
    check_eq("single_byte", 32'(rx_byte), 32'h54);
    check_eq("single_start", 32'(rx_start), 32'd0);
    check_eq("single_stop", 32'(rx_stop), 32'd1);
    check_eq("single_busy_len", 32'(rx_busy), 32'd160);
    check_eq("single_busy_end", 32'(u_if.tx_busy), 32'd0);
    rx_busy = 0;
    for (int i = 0; i < 48; i++) begin
      if (u_if.tx_busy !== 1'b0 || tx_s !== 1'b1) rx_busy++;
      @(negedge clk);
    end
    check_eq("single_no_repeat", 32'(rx_busy), 32'd0);

    // 3: back-to-back "TAMIM" with data_valid held high
    exp_str = '{8'h54, 8'h41, 8'h4D, 8'h49, 8'h4D};
    nxt_str = '{8'h41, 8'h4D, 8'h49, 8'h4D, 8'h4D};
    u_if.data       = 8'h54;
    u_if.data_valid = 1'b1;
    for (int f = 0; f < 5; f++) begin
      rx_frame(nxt_str[f], (f < 4) ? 1'b1 : 1'b0, -1, 8'h00, 1'b0,
               rx_byte, rx_start, rx_stop, rx_wait, rx_busy);
      check_eq($sformatf("b2b_byte%0d", f), 32'(rx_byte), 32'(exp_str[f]));
      check_eq($sformatf("b2b_stop%0d", f), 32'(rx_stop), 32'd1);
      check_eq($sformatf("b2b_busy%0d", f), 32'(rx_busy), 32'd160);
      if (f > 0) check_eq($sformatf("b2b_gap%0d", f), 32'(rx_wait), 32'd16);
    end
    rx_busy = 0;
    for (int i = 0; i < 64; i++) begin
      if (u_if.tx_busy !== 1'b0 || tx_s !== 1'b1) rx_busy++;
      @(negedge clk);
    end
    check_eq("b2b_no_sixth", 32'(rx_busy), 32'd0);

    // 4: inputs change during data bit 3; line keeps 0xA5
    u_if.data       = 8'hA5;
    u_if.data_valid = 1'b1;
    rx_frame(8'hA5, 1'b1, 68, 8'hFF, 1'b0, rx_byte, rx_start, rx_stop, rx_wait, rx_busy);
    check_eq("midchg_byte", 32'(rx_byte), 32'hA5);
    check_eq("midchg_busy_len", 32'(rx_busy), 32'd160);
    check_eq("midchg_stop", 32'(rx_stop), 32'd1);
    repeat (40) @(negedge clk);

    // 5: reset during d4, then a full new frame at the first tick
    u_if.data       = 8'h00;
    u_if.data_valid = 1'b1;
    rx_wait = 0;
    while (tx_s === 1'b1 && rx_wait < 64) begin
      @(negedge clk);
      rx_wait++;
    end
    check_eq("rstmid_started", 32'(u_if.tx_busy), 32'd1);
    repeat (85) @(negedge clk);
    check_eq("rstmid_pre_tx", 32'(tx_s), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_tx", 32'(tx_s), 32'd1);
    check_eq("rstmid_busy", 32'(u_if.tx_busy), 32'd0);
    u_if.data = 8'h96;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_frame(8'h96, 1'b0, -1, 8'h00, 1'b0, rx_byte, rx_start, rx_stop, rx_wait, rx_busy);
    check_eq("rstmid_latency", 32'(rx_wait), 32'd16);
    check_eq("rstmid_byte", 32'(rx_byte), 32'h96);
    check_eq("rstmid_busy_len", 32'(rx_busy), 32'd160);

    // 6: tick spacing and tx edges aligned to ticks over 1000 clks
    begin
      int   last_tick;
      logic prev_tick;
      logic prev_tx;
      last_tick       = -1;
      prev_tick       = dut.baud_tick;
      prev_tx         = tx_s;
      u_if.data       = 8'h5A;
      u_if.data_valid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        if (tx_s !== prev_tx) check_eq("tx_edge_on_tick", 32'(prev_tick), 32'd1);
        if (dut.baud_tick === 1'b1) begin
          if (last_tick >= 0) check_eq("tick_spacing", 32'(n - last_tick), 32'd16);
          last_tick = n;
        end
        prev_tick = dut.baud_tick;
        prev_tx   = tx_s;
      end
      u_if.data_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
